eth_tx_framer: RTL

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

---
 rtl/eth_tx_framer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_framer.sv
// ----------------------------------------------------------------------------
// eth_tx_framer
//
// Turns a raw frame (destination MAC through payload) into a complete line
// frame: 7x 0x55 preamble, 0xD5 SFD, the data, optional zero padding up to
// MIN_LEN, a 4-byte CRC-32 FCS, then an inter-frame gap of IFG_BYTES idle
// cycles. Input bytes travel through an 8-stage delay line, so the preamble
// can be sent while the first data bytes are still in flight.
//
// Parameters
//   PAD_EN     1 = pad short frames with 0x00 up to MIN_LEN, 0 = no padding
//   MIN_LEN    minimum data+pad byte count (FCS excluded)
//   IFG_BYTES  idle cycles after the last FCS byte
//
// Ports
//   clk           tx clock
//   rst_n         asynchronous active-low reset
//   i_data        raw frame byte
//   i_data_en     frame byte valid; one frame = one contiguous high run
//   o_tx_data     line byte to the PHY (registered)
//   o_tx_en       line enable to the PHY (registered)
//   o_busy        high whenever the framer is not idle (registered)
//   o_frame_done  one-cycle pulse alongside the last FCS byte (registered)
//   o_drop        one-cycle pulse when a frame start is rejected (registered)
// ----------------------------------------------------------------------------
module eth_tx_framer #(
    parameter int PAD_EN    = 1,
    parameter int MIN_LEN   = 60,
    parameter int IFG_BYTES = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_data_en,
    output logic [7:0] o_tx_data,
    output logic       o_tx_en,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_drop
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IFG} state_t;

    localparam bit          PAD_ON  = (PAD_EN != 0);
    localparam logic [10:0] MIN_CNT = 11'(MIN_LEN);
    localparam logic [15:0] IFG_CNT = 16'(IFG_BYTES);

    state_t      state, state_next;
    logic [7:0]  dly_data [8];
    logic [7:0]  dly_valid;
    logic        en_q, capturing;
    logic        rise, start, capture;
    logic [10:0] byte_cnt, byte_cnt_next, cnt_inc;
    logic [31:0] crc, crc_next;
    logic [2:0]  pre_cnt, pre_cnt_next;
    logic [1:0]  fcs_cnt, fcs_cnt_next;
    logic [15:0] ifg_cnt, ifg_cnt_next;
    logic [7:0]  tx_data_next;
    logic        tx_en_next, frame_done_next, drop_next;
    logic        body_step, pad_more;

    // One byte of reflected CRC-32 (polynomial 0xEDB88320), LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // A frame is only accepted on a rising i_data_en seen while idle. Bytes
    // are marked valid in the delay line only for that accepted run, so a
    // level left high from a rejected or pre-reset frame never leaks in.
    assign rise    = i_data_en && !en_q;
    assign start   = (state == IDLE) && rise;
    assign capture = i_data_en && (capturing || start);
    assign cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    assign pad_more = PAD_ON && (byte_cnt < MIN_CNT);

    // Delay-line payload; only the valid bits need a reset value.
    always_ff @(posedge clk) begin
        dly_data[0] <= i_data;
        for (int i = 1; i < 8; i++)
            dly_data[i] <= dly_data[i-1];
    end

    // The state always describes the byte currently on the line, so every
    // output is computed one cycle early here and registered below.
    always_comb begin
        state_next      = state;
        tx_data_next    = 8'h00;
        tx_en_next      = 1'b0;
        frame_done_next = 1'b0;
        drop_next       = rise && (state != IDLE);
        crc_next        = crc;
        byte_cnt_next   = byte_cnt;
        pre_cnt_next    = pre_cnt;
        fcs_cnt_next    = fcs_cnt;
        ifg_cnt_next    = ifg_cnt;
        body_step       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = PREAMBLE;
                    tx_data_next  = 8'h55;
                    tx_en_next    = 1'b1;
                    pre_cnt_next  = 3'd0;
                    crc_next      = 32'hFFFFFFFF;
                    byte_cnt_next = 11'd0;
                end
            end
            PREAMBLE: begin
                tx_en_next = 1'b1;
                if (pre_cnt == 3'd7) begin
                    body_step = 1'b1;
                end else begin
                    tx_data_next = (pre_cnt == 3'd6) ? 8'hD5 : 8'h55;
                    pre_cnt_next = pre_cnt + 3'd1;
                end
            end
            DATA, PAD: begin
                body_step = 1'b1;
            end
            FCS: begin
                // fcs_cnt wraps to 0 after the last FCS byte has gone out.
                if (fcs_cnt == 2'd0) begin
                    state_next   = IFG;
                    ifg_cnt_next = 16'd1;
                end else begin
                    tx_en_next      = 1'b1;
                    tx_data_next    = ~crc[{fcs_cnt, 3'b000} +: 8];
                    fcs_cnt_next    = fcs_cnt + 2'd1;
                    frame_done_next = (fcs_cnt == 2'd3);
                end
            end
            IFG: begin
                if (ifg_cnt >= IFG_CNT)
                    state_next = IDLE;
                else
                    ifg_cnt_next = ifg_cnt + 16'd1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Data, pad and the first FCS byte follow each other with no gap:
        // the moment the delay line runs dry, the next byte is already pad
        // or FCS byte 0 (CRC is final because the last body byte updated it).
        if (body_step) begin
            tx_en_next = 1'b1;
            if (dly_valid[7] && (state != PAD)) begin
                state_next    = DATA;
                tx_data_next  = dly_data[7];
                crc_next      = crc32_byte(crc, dly_data[7]);
                byte_cnt_next = cnt_inc;
            end else if (pad_more) begin
                state_next    = PAD;
                tx_data_next  = 8'h00;
                crc_next      = crc32_byte(crc, 8'h00);
                byte_cnt_next = cnt_inc;
            end else begin
                state_next   = FCS;
                tx_data_next = ~crc[7:0];
                fcs_cnt_next = 2'd1;
            end
        end
    end

    // en_q resets high so a frame already streaming when reset releases is
    // not picked up part-way through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            o_tx_data    <= 8'h00;
            o_tx_en      <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_drop       <= 1'b0;
            dly_valid    <= 8'h00;
            capturing    <= 1'b0;
            en_q         <= 1'b1;
            byte_cnt     <= 11'd0;
            crc          <= 32'hFFFFFFFF;
            pre_cnt      <= 3'd0;
            fcs_cnt      <= 2'd0;
            ifg_cnt      <= 16'd0;
        end else begin
            state        <= state_next;
            o_tx_data    <= tx_data_next;
            o_tx_en      <= tx_en_next;
            o_busy       <= (state_next != IDLE);
            o_frame_done <= frame_done_next;
            o_drop       <= drop_next;
            dly_valid    <= {dly_valid[6:0], capture};
            capturing    <= capture;
            en_q         <= i_data_en;
            byte_cnt     <= byte_cnt_next;
            crc          <= crc_next;
            pre_cnt      <= pre_cnt_next;
            fcs_cnt      <= fcs_cnt_next;
            ifg_cnt      <= ifg_cnt_next;
        end
    end

endmodule
